// File: rtl/knn_topk_sorter.sv
// knn_topk_sorter: streaming best-N (distance, type) selector built from a bitonic sorter and merger.
// Optional macro KNN_TOPK_TIE_BREAK_EN: equal distances are ordered by smaller type first.
module knn_topk_sorter #(
   parameter int L      = 2,
   parameter int W      = 16,
   parameter int TYPE_W = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_last,
   input  logic [W*(1<<L)-1:0]        in,
   input  logic [TYPE_W*(1<<L)-1:0]   in_type,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [W*(1<<L)-1:0]        out,
   output logic [TYPE_W*(1<<L)-1:0]   out_type,
   output logic                       busy
);

   localparam int N = 1 << L;
`ifdef KNN_TOPK_TIE_BREAK_EN
   localparam bit TIE_BRK = 1'b1;
`else
   localparam bit TIE_BRK = 1'b0;
`endif
   localparam logic [2:0] LAST_P = 3'(L - 1);

   typedef enum logic [2:0] {IDLE, SORT, MIN, MERGE, OUT} state_t;

   state_t            r_state;
   logic [W-1:0]      r_fd [N];
   logic [TYPE_W-1:0] r_ft [N];
   logic [W-1:0]      r_ld [N];
   logic [TYPE_W-1:0] r_lt [N];
   logic              r_last;
   logic              r_in_ready;
   logic              r_out_valid;
   logic              r_busy;
   logic [2:0]        r_p;
   logic [2:0]        r_q;

   logic [W-1:0]      w_fd [N];
   logic [TYPE_W-1:0] w_ft [N];
   logic [W-1:0]      w_md [N];
   logic [TYPE_W-1:0] w_mt [N];
   logic [W-1:0]      w_ld [N];
   logic [TYPE_W-1:0] w_lt [N];

   // a precedes b: smaller distance, or equal distance and smaller type when tie-break is on
   function automatic logic prec(input logic [W-1:0] ad, input logic [TYPE_W-1:0] at,
                                 input logic [W-1:0] bd, input logic [TYPE_W-1:0] bt);
      return (ad < bd) || (TIE_BRK && (ad == bd) && (at < bt));
   endfunction

   // one bitonic sort column on the frame, block (r_p) and distance (r_q); final order descending
   always_comb begin
      int  p;
      logic dn;
      logic sw;
      p  = 0;
      dn = 1'b0;
      sw = 1'b0;
      w_fd = r_fd;
      w_ft = r_ft;
      for (int i = 0; i < N; i++) begin
         p = i ^ (1 << r_q);
         if (p > i) begin
            dn = ((i >> (r_p + 3'd1)) & 1) == 0;
            sw = dn ? prec(r_fd[i], r_ft[i], r_fd[p], r_ft[p])
                    : prec(r_fd[p], r_ft[p], r_fd[i], r_ft[i]);
            if (sw) begin
               w_fd[i] = r_fd[p];
               w_ft[i] = r_ft[p];
               w_fd[p] = r_fd[i];
               w_ft[p] = r_ft[i];
            end
         end
      end
   end

   // lane-wise minimum of ascending list and descending frame gives a bitonic list
   always_comb begin
      for (int i = 0; i < N; i++) begin
         if (prec(r_fd[i], r_ft[i], r_ld[i], r_lt[i])) begin
            w_md[i] = r_fd[i];
            w_mt[i] = r_ft[i];
         end else begin
            w_md[i] = r_ld[i];
            w_mt[i] = r_lt[i];
         end
      end
   end

   // one ascending half-cleaner column on the list at distance 2^r_q
   always_comb begin
      int p;
      p = 0;
      w_ld = r_ld;
      w_lt = r_lt;
      for (int i = 0; i < N; i++) begin
         p = i ^ (1 << r_q);
         if (p > i && prec(r_ld[p], r_lt[p], r_ld[i], r_lt[i])) begin
            w_ld[i] = r_ld[p];
            w_lt[i] = r_lt[p];
            w_ld[p] = r_ld[i];
            w_lt[p] = r_lt[i];
         end
      end
   end

   // list register drives the result buses at all times
   always_comb begin
      out      = '0;
      out_type = '0;
      for (int i = 0; i < N; i++) begin
         out[W*i +: W]           = r_ld[i];
         out_type[TYPE_W*i +: TYPE_W] = r_lt[i];
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;

   // control FSM with datapath updates and registered handshake outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_last      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_p         <= '0;
         r_q         <= '0;
         for (int i = 0; i < N; i++) begin
            r_fd[i] <= '0;
            r_ft[i] <= '0;
            r_ld[i] <= '1;
            r_lt[i] <= '0;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < N; i++) begin
                     r_fd[i] <= in[W*i +: W];
                     r_ft[i] <= in_type[TYPE_W*i +: TYPE_W];
                  end
                  r_last     <= in_last;
                  r_p        <= '0;
                  r_q        <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= SORT;
               end
            end
            SORT: begin
               r_fd <= w_fd;
               r_ft <= w_ft;
               if (r_q == 3'd0) begin
                  if (r_p == LAST_P) begin
                     r_state <= MIN;
                  end else begin
                     r_p <= r_p + 3'd1;
                     r_q <= r_p + 3'd1;
                  end
               end else begin
                  r_q <= r_q - 3'd1;
               end
            end
            MIN: begin
               r_ld    <= w_md;
               r_lt    <= w_mt;
               r_q     <= LAST_P;
               r_state <= MERGE;
            end
            MERGE: begin
               r_ld <= w_ld;
               r_lt <= w_lt;
               if (r_q == 3'd0) begin
                  if (r_last) begin
                     r_out_valid <= 1'b1;
                     r_state     <= OUT;
                  end else begin
                     r_in_ready <= 1'b1;
                     r_busy     <= 1'b0;
                     r_state    <= IDLE;
                  end
               end else begin
                  r_q <= r_q - 3'd1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  for (int i = 0; i < N; i++) begin
                     r_ld[i] <= '1;
                     r_lt[i] <= '0;
                  end
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_knn_topk_sorter.sv
// tb_knn_topk_sorter: randomized and directed checks of knn_topk_sorter
// against a sort-and-select reference model (L=2 main instance, L=1 side instance).
module tb_knn_topk_sorter;

   localparam int W   = 16;
   localparam int T   = 3;
   localparam int L   = 2;
   localparam int N   = 4;
   localparam int LAT = 6;
`ifdef KNN_TOPK_TIE_BREAK_EN
   localparam bit TB = 1'b1;
`else
   localparam bit TB = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic           in_valid, in_ready, in_last;
   logic [W*N-1:0] in, out;
   logic [T*N-1:0] in_type, out_type;
   logic           out_valid, out_ready, busy;

   logic           in_valid1, in_ready1, in_last1;
   logic [W*2-1:0] in1, out1;
   logic [T*2-1:0] in_type1, out_type1;
   logic           out_valid1, out_ready1, busy1;

   knn_topk_sorter #(.L(L), .W(W), .TYPE_W(T)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in(in), .in_type(in_type),
      .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .out_type(out_type), .busy(busy)
   );

   knn_topk_sorter #(.L(1), .W(W), .TYPE_W(T)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_last(in_last1),
      .in(in1), .in_type(in_type1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out(out1), .out_type(out_type1), .busy(busy1)
   );

   int total = 0;
   int bad   = 0;
   int pd[$];
   int pt[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send(input int d[N], input int t[N], input bit last);
      int c;
      c = 0;
      while (!in_ready && c < 50) begin
         @(posedge clk); #1;
         c++;
      end
      check("ready_wait", in_ready, 1);
      for (int i = 0; i < N; i++) begin
         in[W*i +: W]      = d[i][W-1:0];
         in_type[T*i +: T] = t[i][T-1:0];
         pd.push_back(d[i] & 16'hFFFF);
         pt.push_back(t[i] & 7);
      end
      in_valid = 1'b1;
      in_last  = last;
      @(posedge clk); #1;
      // garbage held on the inputs while busy must be ignored
      in       = {$urandom, $urandom};
      in_type  = 12'($urandom);
      in_last  = 1'b1;
      c = 0;
      do begin
         @(posedge clk); #1;
         c++;
      end while (!(out_valid || in_ready) && c < 40);
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("latency", c, LAT);
      check("end_state", {out_valid, in_ready}, last ? 2'b10 : 2'b01);
   endtask

   task automatic finish_query(input int hold);
      int ad[$], at[$], full[$];
      int ed[N], et[N], cnt, best;
      logic [W*N-1:0] snap;
      ad = pd;
      at = pt;
      for (int i = 0; i < N; i++) begin
         ad.push_back(65535);
         at.push_back(0);
      end
      full = ad;
      for (int i = 0; i < N; i++) begin
         best = 0;
         for (int j = 1; j < ad.size(); j++)
            if (ad[j] < ad[best] || (ad[j] == ad[best] && at[j] < at[best]))
               best = j;
         ed[i] = ad[best];
         et[i] = at[best];
         ad.delete(best);
         at.delete(best);
      end
      for (int i = 0; i < N; i++) begin
         check($sformatf("dist%0d", i), out[W*i +: W], ed[i]);
         cnt = 0;
         foreach (full[j]) if (full[j] == ed[i]) cnt++;
         if (TB || cnt == 1)
            check($sformatf("type%0d", i), out_type[T*i +: T], et[i]);
      end
      snap = out;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         check("hold", {out_valid, in_ready, out}, {1'b1, 1'b0, snap});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("release", {out_valid, in_ready, busy}, 3'b010);
      pd.delete();
      pt.delete();
   endtask

   initial begin
      int d[N], t[N], nf, c;
      rst = 1'b0;
      in_valid = 0; in_last = 0; in = '0; in_type = '0; out_ready = 0;
      in_valid1 = 0; in_last1 = 0; in1 = '0; in_type1 = '0; out_ready1 = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      check("rst_flags", {in_ready, out_valid, busy}, 3'b100);
      check("rst_list", {out, out_type}, {{(W*N){1'b1}}, {(T*N){1'b0}}});

      send('{9, 3, 7, 1}, '{0, 1, 2, 3}, 1'b1);
      finish_query(0);

      send('{9, 3, 7, 1}, '{0, 1, 2, 3}, 1'b0);
      send('{2, 8, 0, 5}, '{0, 1, 2, 3}, 1'b1);
      finish_query(0);

      send('{11, 40, 6, 12}, '{1, 5, 7, 2}, 1'b1);
      finish_query(10);

      // reset during the second sort cycle
      for (int i = 0; i < N; i++) in[W*i +: W] = 16'(20 + i);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      check("abort", {busy, in_ready, out_valid}, 3'b010);
      send('{4, 4, 4, 4}, '{1, 6, 3, 2}, 1'b1);
      finish_query(0);

      send('{5, 5, 5, 5}, '{3, 2, 1, 0}, 1'b1);
      finish_query(0);

      for (int q = 0; q < 20; q++) begin
         nf = $urandom_range(1, 3);
         for (int f = 0; f < nf; f++) begin
            for (int i = 0; i < N; i++) begin
               case ($urandom_range(0, 3))
                  0: d[i] = 65535;
                  1: d[i] = int'($urandom & 16'hFFFF);
                  default: d[i] = $urandom_range(0, 12);
               endcase
               t[i] = $urandom_range(0, 7);
            end
            send(d, t, f == nf - 1);
         end
         finish_query($urandom_range(0, 3));
      end

      // L=1 instance
      in1 = {16'd2, 16'd7};
      in_type1 = {3'd5, 3'd1};
      in_last1 = 1'b1;
      in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      in_last1 = 1'b0;
      c = 0;
      while (!out_valid1 && c < 20) begin
         @(posedge clk); #1;
         c++;
      end
      check("l1_latency", c, 3);
      check("l1_out", out1, {16'd7, 16'd2});
      check("l1_type", out_type1, {3'd1, 3'd5});
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
      check("l1_release", {out_valid1, in_ready1, out1}, {2'b01, {(W*2){1'b1}}});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
